// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller: FSM states, access owner,
// and the width/saturation helper for the optional statistics counters.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// Fixed-latency timer for one memory access: loaded on grant, counts down while
// the access runs and flags the last access cycle.
module dmem_lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic done
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MEM_LAT - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (start) begin
            cnt_reg <= LOAD;
        end else if (run && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = run && (cnt_reg == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-port data memory sequencer shared by the MEM stage and a debug/loader port.
// Optional build macro ACCESS_STATS_EN adds stall_cycles / dbg_grants counters.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_rd,
    input  logic              pipe_wr,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ACCESS_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] dbg_grants
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t              state_reg, state_next;
    owner_t              owner_reg;
    logic [SW-1:0]       starve_reg;
    logic                mem_en_reg, mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [DATA_W-1:0]   pipe_rdata_reg, dbg_rdata_reg;
    logic                pipe_req, starved, grant_pipe, grant_dbg, lat_done;
    logic                addr_lsb_unused;

    assign pipe_req = pipe_rd | pipe_wr;
    assign starved  = (starve_reg == SW'(STARVE_MAX));
    // Word-aligned memory: the byte-offset bits never reach the array.
    assign addr_lsb_unused = ^{pipe_addr[1:0], dbg_addr[1:0]};

    // Pipeline has priority unless debug has lost STARVE_MAX arbitrations in a row.
    always_comb begin
        grant_pipe = 1'b0;
        grant_dbg  = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (dbg_req && (starved || !pipe_req)) begin
                grant_dbg = 1'b1;
            end else if (pipe_req) begin
                grant_pipe = 1'b1;
            end
        end
    end

    dmem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat (
        .clk   (clk),
        .rst   (rst),
        .start (grant_pipe | grant_dbg),
        .run   (state_reg == ST_ACCESS),
        .done  (lat_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (grant_pipe || grant_dbg) state_next = ST_ACCESS;
            ST_ACCESS: if (lat_done) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg      <= OWN_PIPE;
            starve_reg     <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            pipe_rdata_reg <= '0;
            dbg_rdata_reg  <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            if (grant_pipe) begin
                owner_reg     <= OWN_PIPE;
                mem_en_reg    <= 1'b1;
                mem_we_reg    <= pipe_wr;
                mem_addr_reg  <= {pipe_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_reg <= pipe_wdata;
                if (dbg_req && !starved) begin
                    starve_reg <= starve_reg + 1'b1;
                end
            end else if (grant_dbg) begin
                owner_reg     <= OWN_DBG;
                mem_en_reg    <= 1'b1;
                mem_we_reg    <= dbg_we;
                mem_addr_reg  <= {dbg_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_reg <= dbg_wdata;
                starve_reg    <= '0;
            end else if ((state_reg == ST_ACCESS) && lat_done) begin
                mem_en_reg <= 1'b0;
            end
            if (state_reg == ST_DONE) begin
                if (owner_reg == OWN_PIPE) begin
                    pipe_rdata_reg <= mem_rdata;
                end else begin
                    dbg_rdata_reg <= mem_rdata;
                end
            end
        end
    end

    // Read data bypasses the capture register so it is valid in the DONE cycle itself.
    always_comb begin
        pipe_stall = pipe_req && !((state_reg == ST_DONE) && (owner_reg == OWN_PIPE));
        dbg_ack    = (state_reg == ST_DONE) && (owner_reg == OWN_DBG) && dbg_req;
        pipe_rdata = pipe_rdata_reg;
        dbg_rdata  = dbg_rdata_reg;
        if (state_reg == ST_DONE) begin
            if (owner_reg == OWN_PIPE) begin
                pipe_rdata = mem_rdata;
            end else begin
                dbg_rdata = mem_rdata;
            end
        end
    end

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

`ifdef ACCESS_STATS_EN
    logic [STAT_W-1:0] stall_cnt_reg, grant_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            grant_cnt_reg <= '0;
        end else begin
            if (pipe_stall) stall_cnt_reg <= sat_inc(stall_cnt_reg);
            if (grant_dbg)  grant_cnt_reg <= sat_inc(grant_cnt_reg);
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign dbg_grants   = grant_cnt_reg;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: memory device model, schedule-based reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_dmem_access_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int NWORDS     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_rd = 1'b0, pipe_wr = 1'b0;
    logic [31:0] pipe_addr = '0, pipe_wdata = '0;
    logic [31:0] pipe_rdata;
    logic        pipe_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ACCESS_STATS_EN
    logic [15:0] stall_cycles, dbg_grants;
`endif

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_rd    (pipe_rd),
        .pipe_wr    (pipe_wr),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .pipe_rdata (pipe_rdata),
        .pipe_stall (pipe_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef ACCESS_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .dbg_grants   (dbg_grants)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory device: data appears MEM_LAT cycles after the first enabled cycle.
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    logic [31:0] dev_mem [NWORDS];
    logic [31:0] rd_pipe [MEM_LAT];

    always @(posedge clk) begin
        if (pl_en) dev_mem[pl_idx] <= pl_val;
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr[5:2]] <= mem_wdata;
            rd_pipe[0] <= dev_mem[mem_addr[5:2]];
        end
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // Reference model: a granted access occupies the memory for cycles g+1..g+MEM_LAT
    // and completes at g+MEM_LAT+1; the next arbitration happens the cycle after that.
    logic [31:0] ref_mem [NWORDS];
    int          mon_cyc = 0;
    int          m_g = -1, m_k = 0, m_starve = 0, m_stall = 0, m_grants = 0;
    bit          m_dbg, m_we, m_preq, gp, gd;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          e_en, e_we, e_ack, e_stall;
    bit          mon_pipe_done = 0, mon_ack = 0;
    int          we_pulses = 0, ack_count = 0;

    always @(negedge clk) begin
        mon_cyc++;
        mon_pipe_done = (pipe_rd || pipe_wr) && !pipe_stall;
        mon_ack       = dbg_ack;
        if (pl_en) ref_mem[pl_idx] = pl_val;
        if (mem_we) we_pulses++;
        if (dbg_ack) ack_count++;
        if (rst) begin
            m_g = -1; m_starve = 0; m_stall = 0; m_grants = 0;
        end else begin
            m_preq  = pipe_rd || pipe_wr;
            e_en = 0; e_we = 0; e_ack = 0; e_stall = m_preq;
            gp = 0; gd = 0;
            if (m_g >= 0) begin
                m_k = mon_cyc - m_g;
                if (m_k <= MEM_LAT) begin
                    e_en = 1;
                    e_we = (m_k == 1) && m_we;
                end else begin
                    if (m_dbg) begin
                        e_ack = dbg_req;
                        if (dbg_req && !m_we) check("dbg_rdata", dbg_rdata, m_rdata);
                    end else begin
                        e_stall = 0;
                        if (!m_we) check("pipe_rdata", pipe_rdata, m_rdata);
                    end
                    m_g = -1;
                end
            end else begin
                gp = m_preq && !(dbg_req && (m_starve == STARVE_MAX));
                gd = dbg_req && !gp;
                if (gp || gd) begin
                    m_g   = mon_cyc;
                    m_dbg = gd;
                    if (gp) begin
                        m_we = pipe_wr; m_addr = pipe_addr; m_wdata = pipe_wdata;
                        if (dbg_req) m_starve++;
                    end else begin
                        m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
                        m_starve = 0;
                    end
                    m_rdata = ref_mem[m_addr[5:2]];
                    if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
                end
            end
            check("mem_en", 32'(mem_en), 32'(e_en));
            check("mem_we", 32'(mem_we), 32'(e_we));
            if (e_en) check("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
            if (e_we) check("mem_wdata", mem_wdata, m_wdata);
            check("pipe_stall", 32'(pipe_stall), 32'(e_stall));
            check("dbg_ack", 32'(dbg_ack), 32'(e_ack));
`ifdef ACCESS_STATS_EN
            check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
            check("dbg_grants", 32'(dbg_grants), 32'(m_grants));
`endif
            if (e_stall && m_stall < 65535) m_stall++;
            if (gd && m_grants < 65535) m_grants++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_idx = 4'(idx);
        pl_val = val;
        pl_en  = 1'b1;
        tick();
        pl_en  = 1'b0;
    endtask

    task automatic wait_pipe(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!pipe_stall) return;
            n++;
        end
        check("pipe_timeout", 32'd1, 32'd0);
    endtask

    task automatic new_pipe_op();
        pipe_wr    = ($urandom_range(0, 2) == 0);
        pipe_rd    = pipe_wr ? 1'($urandom_range(0, 1)) : 1'b1;
        pipe_addr  = 32'($urandom_range(0, 63));
        pipe_wdata = $urandom;
    endtask

    int  n, m, np, a0, d_cool;
    bit  got, p_active;

    initial begin
        tick();
        for (int i = 0; i < NWORDS; i++) preload(i, $urandom);
        preload(4, 32'hDEADBEEF);
        preload(12, 32'h0DB60030);
        preload(2, 32'hA5A50F0F);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        check("rst_pipe_rdata", pipe_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // Directed 1: load from 0x10
        tick();
        pipe_rd = 1; pipe_addr = 32'h10;
        wait_pipe(n);
        check("t1_stall_cycles", 32'(n), 32'd3);
        check("t1_rdata", pipe_rdata, 32'hDEADBEEF);

        // Directed 2: store then immediate load of the same word
        tick();
        pipe_rd = 0; pipe_wr = 1; pipe_addr = 32'h20; pipe_wdata = 32'h12345678;
        a0 = we_pulses;
        wait_pipe(n);
        tick();
        check("t2_we_pulses", 32'(we_pulses - a0), 32'd1);
        pipe_wr = 0; pipe_rd = 1;
        wait_pipe(n);
        check("t2_load_stall", 32'(n), 32'd3);
        check("t2_rdata", pipe_rdata, 32'h12345678);
        tick();
        pipe_rd = 0;
        tick();

        // Directed 3: debug starved by continuous pipe loads, twice
        for (int r = 0; r < 2; r++) begin
            a0 = ack_count; np = 0; got = 0;
            dbg_req = 1; dbg_we = 0; dbg_addr = 32'h30;
            pipe_rd = 1; pipe_addr = 32'h10;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (!pipe_stall) np++;
                if (dbg_ack) begin
                    got = 1;
                    check("t3_dbg_rdata", dbg_rdata, 32'h0DB60030);
                end
            end
            check("t3_got_ack", 32'(got), 32'd1);
            check("t3_pipe_before_dbg", 32'(np), 32'd4);
            tick();
            dbg_req = 0;
            repeat (8) @(negedge clk);
            check("t3_ack_pulses", 32'(ack_count - a0), 32'd1);
`ifdef ACCESS_STATS_EN
            check("t3_dbg_grants", 32'(dbg_grants), 32'(r + 1));
`endif
            wait_pipe(n);
            tick();
            pipe_rd = 0;
            tick();
        end

        // Directed 4: simultaneous requests, pipe first then debug
        a0 = ack_count;
        pipe_rd = 1; pipe_addr = 32'h14;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h18;
        wait_pipe(n);
        check("t4_pipe_first", 32'(n), 32'd3);
        check("t4_no_early_ack", 32'(ack_count - a0), 32'd0);
        tick();
        pipe_rd = 0;
        m = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            m++;
            if (dbg_ack) got = 1;
        end
        check("t4_dbg_next", 32'(m), 32'(MEM_LAT + 2));
        tick();
        dbg_req = 0;

        // Directed 5: reset in the first access cycle
        pipe_rd = 1; pipe_addr = 32'h08;
        tick();
        rst = 1; pipe_rd = 0;
        tick();
        rst = 0;
        @(negedge clk);
        check("t5_mem_en", 32'(mem_en), 32'd0);
        check("t5_mem_we", 32'(mem_we), 32'd0);
        check("t5_mem_addr", mem_addr, 32'd0);
        check("t5_mem_wdata", mem_wdata, 32'd0);
        check("t5_pipe_stall", 32'(pipe_stall), 32'd0);
        check("t5_dbg_ack", 32'(dbg_ack), 32'd0);
        check("t5_pipe_rdata", pipe_rdata, 32'd0);
        check("t5_dbg_rdata", dbg_rdata, 32'd0);
        tick();
        pipe_rd = 1; pipe_addr = 32'h0B;
        wait_pipe(n);
        check("t5_reload_stall", 32'(n), 32'd3);
        check("t5_reload_rdata", pipe_rdata, 32'hA5A50F0F);
        tick();
        pipe_rd = 0;

        // Random traffic from both requesters
        p_active = 0; d_cool = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (p_active) begin
                if (mon_pipe_done) begin
                    if ($urandom_range(0, 9) < 6) new_pipe_op();
                    else begin pipe_rd = 0; pipe_wr = 0; p_active = 0; end
                end
            end else if ($urandom_range(0, 9) < 3) begin
                new_pipe_op();
                p_active = 1;
            end
            if (dbg_req) begin
                if (mon_ack) begin
                    dbg_req = 0; d_cool = $urandom_range(0, 3);
                end else if ($urandom_range(0, 63) == 0) begin
                    dbg_req = 0; d_cool = MEM_LAT + 3;
                end
            end else if (d_cool > 0) begin
                d_cool--;
            end else if ($urandom_range(0, 4) == 0) begin
                dbg_req   = 1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 32'($urandom_range(0, 63));
                dbg_wdata = $urandom;
            end
        end
        pipe_rd = 0; pipe_wr = 0; dbg_req = 0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
